ysyx_22041071_axi_rd_slave: RTL and testbench
=============================================

Name: ysyx_22041071_axi_rd_slave

Overview:
- AXI4 read-channel responder (AR accept + R return) that serves the core's instruction-fetch and load read requests from an internal 64-bit word memory.
- Sits at the far end of the CPU's AR/R interface.
- Provides configurable first-beat latency, INCR/FIXED bursts, R backpressure and a backdoor preload port for simulation and bring-up.

Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of memory word 0.
- DEPTH, 1024, number of 64-bit words.
- LATENCY, 2, cycles from AR handshake to first RVALID; legal range 1..15.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- araddr  in  64  byte address.
- arlen  in  8  beats minus 1.
- arsize  in  3  log2 bytes per beat.
- arburst  in  2  burst type: 00 FIXED, 01 INCR, other unsupported.
- arid  in  ID_W  transaction ID.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rdata  out  64  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  last beat of burst.
- rid  out  ID_W  echo of arid.
- bd_wen  in  1  backdoor write enable.
- bd_idx  in  log2(DEPTH)  backdoor word index.
- bd_wdata  in  64  backdoor data.
- bd_wstrb  in  8  backdoor byte strobes.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0, latency counter and beat counter cleared. An in-flight burst is discarded with no further beats. Memory contents are not reset.
- The first rising clk edge after reset releases sets arready=1.
- States:
  - IDLE: arready=1. On arvalid&arready, capture araddr/arlen/arsize/arburst/arid, load latency counter with LATENCY-1, clear arready, go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, register beat 0 (rdata/rresp/rlast/rid), assert rvalid, go to DATA. With LATENCY=1, rvalid is high in the cycle immediately after the AR handshake.
  - DATA: rvalid, rdata, rresp, rlast and rid are held stable while rready=0.
    - On rvalid&rready with rlast=0: advance the address and register the next beat on the same edge; rvalid stays 1, giving 1 beat/cycle throughput.
    - On rvalid&rready with rlast=1: rvalid=0, rlast=0, arready=1, go to IDLE. A new AR is accepted no earlier than the cycle after the last R handshake.
- Beat count is arlen+1 (1..256). rlast=1 exactly on beat arlen.
- Address advance:
  - INCR: next = (addr & ~(2^arsize - 1)) + 2^arsize, so the first beat may be unaligned and later beats are aligned.
  - FIXED: address unchanged for every beat.
  - 64-bit arithmetic; wrap at 2^64 is not special-cased.
- Data: rdata is the full 64-bit memory word at index (addr - BASE_ADDR) >> 3. Byte lanes are not shifted; the master selects lanes.
- SLVERR conditions, evaluated per beat: addr < BASE_ADDR, or addr >= BASE_ADDR + 8*DEPTH.
- SLVERR conditions, applied to all beats of the burst: arsize > 3, or arburst not in {00, 01}.
- An SLVERR beat returns rdata=0. An INCR burst crossing the top of memory returns OKAY beats up to the boundary and SLVERR beats after it; the beat count is always honoured.
- Backdoor port:
  - bd_wen writes strobed bytes on the clk edge, in any state.
  - A beat registered on the same edge as a write to its word returns the old data.
  - A word rewritten while its beat is already held under backpressure does not change rdata.
- arvalid is ignored outside IDLE; the master must hold it until arready.

Test Plan:
- Preload word 0 = 64'h1111_2222_3333_4444, LATENCY=2; AR addr 0x8000_0000, len 0, size 3, INCR, id 5, rready=1 → rvalid high 2 cycles after handshake, rdata=64'h1111_2222_3333_4444, rlast=1, rresp=00, rid=5, arready high the next cycle.
- Preload words 0..3 = 0xA0..0xA3; AR 0x8000_0000, len 3, size 3, INCR, rready=1 → 4 consecutive beats 0xA0..0xA3, rlast only on the 4th beat.
- Same burst with rready toggling 1,0,0,1,0,1,1 → rdata/rlast stable during stalls; exactly 4 handshakes with data in order.
- AR 0x8000_1FF8 (last word), len 1, INCR → beat 0 OKAY with the word data; beat 1 SLVERR with rdata=0 and rlast=1.
- AR arburst=2'b10, len 2 → 3 SLVERR beats, rdata=0; AR addr 0x7FFF_FFF8 → SLVERR.
- Assert reset during beat 1 of a 4-beat burst → rvalid drops immediately; arready=0 until the first edge after release, then 1; a new single-beat read completes normally.

Source files
------------

// File: rtl/ysyx_22041071_axi_rd_slave.sv
// AXI4 read responder: AR accept, fixed first-beat latency, INCR/FIXED bursts from a 64-bit word memory.
// Latency LATENCY cycles AR->first RVALID, then 1 beat/cycle; R beats held stable while rready=0, AR blocked until burst ends.
module ysyx_22041071_axi_rd_slave #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 2,
   parameter int          ID_W      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     arvalid,
   output logic                     arready,
   input  logic [63:0]              araddr,
   input  logic [7:0]               arlen,
   input  logic [2:0]               arsize,
   input  logic [1:0]               arburst,
   input  logic [ID_W-1:0]          arid,
   output logic                     rvalid,
   input  logic                     rready,
   output logic [63:0]              rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic [ID_W-1:0]          rid,
   input  logic                     bd_wen,
   input  logic [$clog2(DEPTH)-1:0] bd_idx,
   input  logic [63:0]              bd_wdata,
   input  logic [7:0]               bd_wstrb
);

   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [63:0] TOP_ADDR = BASE_ADDR + (64'(DEPTH) << 3);
   localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

   state_t           r_state;
   logic [3:0]       r_lat;
   logic [7:0]       r_beat;
   logic [7:0]       r_len;
   logic [63:0]      r_addr;
   logic [2:0]       r_size;
   logic             r_fixed;
   logic             r_burst_err;
   logic [ID_W-1:0]  r_id;
   logic [63:0]      r_mem [DEPTH];

   logic [63:0]      w_bytes;
   logic [63:0]      w_next_addr;
   logic [63:0]      w_beat_addr;
   logic [63:0]      w_off;
   logic [IDX_W-1:0] w_idx;
   logic             w_err;
   logic [63:0]      w_beat_dat;
   logic [1:0]       w_beat_resp;

   // Backdoor preload; reads in the FSM below see the pre-write word on the same edge.
   always_ff @(posedge clk) begin
      if (bd_wen) begin
         for (int b = 0; b < 8; b++) begin
            if (bd_wstrb[b]) r_mem[bd_idx][b*8 +: 8] <= bd_wdata[b*8 +: 8];
         end
      end
   end

   // Beat 0 comes from the captured address; later beats from the advanced one.
   assign w_bytes     = 64'd1 << r_size;
   assign w_next_addr = r_fixed ? r_addr : ((r_addr & ~(w_bytes - 64'd1)) + w_bytes);
   assign w_beat_addr = (r_state == S_DATA) ? w_next_addr : r_addr;
   assign w_off       = w_beat_addr - BASE_ADDR;
   assign w_idx       = IDX_W'(w_off >> 3);
   assign w_err       = r_burst_err || (w_beat_addr < BASE_ADDR) || (w_beat_addr >= TOP_ADDR);
   assign w_beat_dat  = w_err ? 64'd0 : r_mem[w_idx];
   assign w_beat_resp = w_err ? 2'b10 : 2'b00;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         arready     <= 1'b0;
         rvalid      <= 1'b0;
         rlast       <= 1'b0;
         rresp       <= 2'b00;
         rdata       <= 64'd0;
         rid         <= '0;
         r_lat       <= 4'd0;
         r_beat      <= 8'd0;
         r_len       <= 8'd0;
         r_addr      <= 64'd0;
         r_size      <= 3'd0;
         r_fixed     <= 1'b0;
         r_burst_err <= 1'b0;
         r_id        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (arvalid && arready) begin
                  r_addr      <= araddr;
                  r_len       <= arlen;
                  r_size      <= arsize;
                  r_fixed     <= (arburst == 2'b00);
                  r_burst_err <= (arsize > 3'd3) || arburst[1];
                  r_id        <= arid;
                  r_lat       <= LAT_LOAD;
                  arready     <= 1'b0;
                  r_state     <= S_WAIT;
               end else begin
                  arready <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_lat == 4'd0) begin
                  rdata   <= w_beat_dat;
                  rresp   <= w_beat_resp;
                  rlast   <= (r_len == 8'd0);
                  rid     <= r_id;
                  rvalid  <= 1'b1;
                  r_beat  <= 8'd0;
                  r_state <= S_DATA;
               end else begin
                  r_lat <= r_lat - 4'd1;
               end
            end
            S_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     arready <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_addr <= w_next_addr;
                     rdata  <= w_beat_dat;
                     rresp  <= w_beat_resp;
                     rlast  <= ((r_beat + 8'd1) == r_len);
                     r_beat <= r_beat + 8'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_slave.sv
// Scoreboard bench for the AXI read responder: expected beats queued at AR issue, compared at each R handshake.
module tb_ysyx_22041071_axi_rd_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic        arvalid;
   logic        arready;
   logic [63:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arid;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   logic        bd_wen;
   logic [9:0]  bd_idx;
   logic [63:0] bd_wdata;
   logic [7:0]  bd_wstrb;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [63:0] dat;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } beat_t;

   beat_t exp_q[$];

   ysyx_22041071_axi_rd_slave dut (
      .clk(clk), .reset(reset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arid(arid),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid),
      .bd_wen(bd_wen), .bd_idx(bd_idx), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb)
   );

   always #5 clk = ~clk;

   task automatic bd_write(input logic [9:0] idx, input logic [63:0] d, input logic [7:0] s);
      bd_wen = 1'b1; bd_idx = idx; bd_wdata = d; bd_wstrb = s;
      @(negedge clk);
      bd_wen = 1'b0;
   endtask

   task automatic push(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
      beat_t e;
      e.dat = d; e.resp = r; e.last = l; e.id = id;
      exp_q.push_back(e);
   endtask

   task automatic ar_issue(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
      int g = 0;
      while (!arready && g < 50) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (arready !== 1'b1) begin
         n_fail++;
         $display("FAIL ar_wait: arready=%b after %0d cycles, required 1", arready, g);
      end
      araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   // Drains the queue; pat bit k is rready on the k-th cycle with rvalid high, then 1.
   task automatic collect(input logic [15:0] pat, input int plen);
      int          k = 0;
      int          guard = 0;
      logic        stall = 1'b0;
      logic [63:0] sdat = '0;
      logic        slast = 1'b0;
      beat_t       e;
      while (exp_q.size() > 0 && guard < 300) begin
         if (rvalid) begin
            rready = (k < plen) ? pat[k] : 1'b1;
            k++;
            if (stall) begin
               n_checks++;
               if (rdata !== sdat || rlast !== slast) begin
                  n_fail++;
                  $display("FAIL stall_hold: rdata=%h rlast=%b, required %h %b", rdata, rlast, sdat, slast);
               end
            end
            if (rready) begin
               e = exp_q.pop_front();
               n_checks++;
               if (rdata !== e.dat || rresp !== e.resp || rlast !== e.last || rid !== e.id) begin
                  n_fail++;
                  $display("FAIL beat: data=%h resp=%b last=%b id=%h, required %h %b %b %h",
                           rdata, rresp, rlast, rid, e.dat, e.resp, e.last, e.id);
               end
               stall = 1'b0;
            end else begin
               stall = 1'b1; sdat = rdata; slast = rlast;
            end
         end else begin
            rready = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      rready = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL beat_timeout: %0d beats outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_after: rvalid=%b arready=%b, required 0 1", rvalid, arready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arid = '0;
      rready = 1'b0; bd_wen = 1'b0; bd_idx = '0; bd_wdata = '0; bd_wstrb = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 ||
          rdata !== 64'd0 || rid !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h rid=%h, required all 0",
                  arready, rvalid, rlast, rresp, rdata, rid);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (arready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: arready=%b before first edge, required 0", arready);
      end
      @(negedge clk);
      n_checks++;
      if (arready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_arready: arready=%b after first edge, required 1", arready);
      end
   endtask

   task automatic test_single();
      int k = 0;
      bd_write(10'd0, 64'h1111_2222_3333_4444, 8'hFF);
      ar_issue(64'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd5);
      while (!rvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k != 2) begin
         n_fail++;
         $display("FAIL latency: first rvalid %0d cycles after handshake, required 2", k);
      end
      push(64'h1111_2222_3333_4444, 2'b00, 1'b1, 4'd5);
      collect(16'hFFFF, 16);
   endtask

   task automatic test_burst();
      for (int i = 0; i < 4; i++) bd_write(10'(i), 64'hA0 + 64'(i), 8'hFF);
      ar_issue(64'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd2);
      for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i), 2'b00, i == 3, 4'd2);
      collect(16'hFFFF, 16);
   endtask

   task automatic test_backpressure();
      ar_issue(64'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd9);
      for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i), 2'b00, i == 3, 4'd9);
      collect(16'h0069, 7);
   endtask

   task automatic test_fixed_unaligned();
      ar_issue(64'h8000_0008, 8'd2, 3'd3, 2'b00, 4'd3);
      for (int i = 0; i < 3; i++) push(64'hA1, 2'b00, i == 2, 4'd3);
      collect(16'hFFFF, 16);
      // 4-byte beats from byte 4: words 0, 1, 1.
      ar_issue(64'h8000_0004, 8'd2, 3'd2, 2'b01, 4'd4);
      push(64'hA0, 2'b00, 1'b0, 4'd4);
      push(64'hA1, 2'b00, 1'b0, 4'd4);
      push(64'hA1, 2'b00, 1'b1, 4'd4);
      collect(16'hFFFF, 16);
   endtask

   task automatic test_errors();
      bd_write(10'd1023, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF);
      ar_issue(64'h8000_1FF8, 8'd1, 3'd3, 2'b01, 4'd6);
      push(64'hCAFE_F00D_0BAD_BEEF, 2'b00, 1'b0, 4'd6);
      push(64'd0, 2'b10, 1'b1, 4'd6);
      collect(16'hFFFF, 16);
      ar_issue(64'h8000_0000, 8'd2, 3'd3, 2'b10, 4'd7);
      for (int i = 0; i < 3; i++) push(64'd0, 2'b10, i == 2, 4'd7);
      collect(16'hFFFF, 16);
      ar_issue(64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'd8);
      push(64'd0, 2'b10, 1'b1, 4'd8);
      collect(16'hFFFF, 16);
      ar_issue(64'h8000_0000, 8'd0, 3'd4, 2'b01, 4'd1);
      push(64'd0, 2'b10, 1'b1, 4'd1);
      collect(16'hFFFF, 16);
   endtask

   task automatic test_backdoor_hold();
      int k = 0;
      bd_write(10'd5, 64'h0000_0000_0000_5555, 8'hFF);
      ar_issue(64'h8000_0028, 8'd0, 3'd3, 2'b01, 4'd7);
      while (!rvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      bd_write(10'd5, 64'h0000_0000_0000_9999, 8'hFF);
      push(64'h0000_0000_0000_5555, 2'b00, 1'b1, 4'd7);
      collect(16'h0002, 2);
      bd_write(10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      ar_issue(64'h8000_0028, 8'd0, 3'd3, 2'b01, 4'd7);
      push(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1, 4'd7);
      collect(16'hFFFF, 16);
   endtask

   task automatic test_reset_mid_burst();
      int k = 0;
      ar_issue(64'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd2);
      while (!rvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      rready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 64'hA1) begin
         n_fail++;
         $display("FAIL mid_beat1: rvalid=%b rdata=%h, required 1 a1", rvalid, rdata);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: rvalid=%b rlast=%b arready=%b, required 0 0 0", rvalid, rlast, arready);
      end
      rready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (arready !== 1'b0 || rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_release: arready=%b rvalid=%b, required 0 0", arready, rvalid);
      end
      @(negedge clk);
      n_checks++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rearm: arready=%b rvalid=%b, required 1 0", arready, rvalid);
      end
      ar_issue(64'h8000_0010, 8'd0, 3'd3, 2'b01, 4'd3);
      push(64'hA2, 2'b00, 1'b1, 4'd3);
      collect(16'hFFFF, 16);
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_fixed_unaligned();
      test_errors();
      test_backdoor_hold();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
